// File: rtl/led_sequence_ctrl.sv
// Four-switch LED sequencer: synchronized, debounced switch releases step a
// MANUAL/CHASE/BLINK/OFF mode machine that drives four registered LEDs.
module led_sequence_ctrl #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned CHASE_TICKS    = 6250000,
  parameter int unsigned BLINK_TICKS    = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);

  localparam int unsigned NUM_SW   = 4;
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int unsigned TICK_MAX = (CHASE_TICKS > BLINK_TICKS) ? CHASE_TICKS : BLINK_TICKS;
  localparam int unsigned TICK_W   = $clog2(TICK_MAX);

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [TICK_W-1:0] CHASE_LAST = TICK_W'(CHASE_TICKS - 1);
  localparam logic [TICK_W-1:0] BLINK_LAST = TICK_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  logic [NUM_SW-1:0]           sw_raw;
  logic [NUM_SW-1:0]           sync1_q;
  logic [NUM_SW-1:0]           sync2_q;
  logic [NUM_SW-1:0]           deb_q;
  logic [NUM_SW-1:0]           deb_prev_q;
  logic [NUM_SW-1:0][DB_W-1:0] db_cnt_q;
  logic [NUM_SW-1:0]           rel_c;

  mode_e             mode_q;
  logic [3:0]        led_q;
  logic [2:0]        man_q;
  logic              dir_rev_q;
  logic [TICK_W-1:0] tick_q;
  logic [2:0]        man_d;
  logic              dir_rev_d;

  assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  // Two-flop synchronizer, then a per-switch stability counter.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= sw_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int k = 0; k < NUM_SW; k++) begin
        if (sync2_q[k] == deb_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_LAST) begin
          deb_q[k]    <= sync2_q[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  // One-cycle pulse on each debounced 1->0 transition.
  assign rel_c     = deb_prev_q & ~deb_q;
  assign man_d     = man_q ^ rel_c[2:0];
  assign dir_rev_d = dir_rev_q ^ rel_c[0];

  // Mode machine; switch 4 wins over any coincident release.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode_q    <= MODE_MANUAL;
      led_q     <= '0;
      man_q     <= '0;
      dir_rev_q <= 1'b0;
      tick_q    <= '0;
    end else if (rel_c[3]) begin
      tick_q <= '0;
      unique case (mode_q)
        MODE_MANUAL: begin
          mode_q    <= MODE_CHASE;
          led_q     <= 4'b0001;
          dir_rev_q <= 1'b0;
        end
        MODE_CHASE: begin
          mode_q <= MODE_BLINK;
          led_q  <= 4'b1111;
        end
        MODE_BLINK: begin
          mode_q <= MODE_OFF;
          led_q  <= 4'b0000;
        end
        MODE_OFF: begin
          mode_q <= MODE_MANUAL;
          led_q  <= {1'b0, man_q};
        end
      endcase
    end else begin
      unique case (mode_q)
        MODE_MANUAL: begin
          man_q  <= man_d;
          led_q  <= {1'b0, man_d};
          tick_q <= '0;
        end
        MODE_CHASE: begin
          dir_rev_q <= dir_rev_d;
          if (tick_q == CHASE_LAST) begin
            tick_q <= '0;
            // led_q[0] is LED1; forward walks toward LED4.
            led_q  <= dir_rev_d ? {led_q[0], led_q[3:1]} : {led_q[2:0], led_q[3]};
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        MODE_BLINK: begin
          if (tick_q == BLINK_LAST) begin
            tick_q <= '0;
            led_q  <= ~led_q;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        MODE_OFF: begin
          led_q  <= '0;
          tick_q <= '0;
        end
      endcase
    end
  end

  assign o_LED_1 = led_q[0];
  assign o_LED_2 = led_q[1];
  assign o_LED_3 = led_q[2];
  assign o_LED_4 = led_q[3];
  assign o_Mode  = mode_q;

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Scoreboard bench for led_sequence_ctrl: stimulus queues the expected output
// changes (edge number, mode, LED1..4) and a monitor checks each change seen.
module tb_led_sequence_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned CT  = 3;
  localparam int unsigned BT  = 5;
  localparam int          LAT = DB + 3;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [3:0] led;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       led1, led2, led3, led4;
  logic [1:0] mode;
  logic [3:0] led_vec;

  exp_t       q[$];
  exp_t       mon_e;
  int         total    = 0;
  int         bad      = 0;
  int         edge_cnt = 0;
  bit         mon_en   = 1'b0;
  logic [5:0] prev     = '0;

  led_sequence_ctrl #(
    .DEBOUNCE_LIMIT(DB),
    .CHASE_TICKS   (CT),
    .BLINK_TICKS   (BT)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Switch_1(sw[0]),
    .i_Switch_2(sw[1]),
    .i_Switch_3(sw[2]),
    .i_Switch_4(sw[3]),
    .o_LED_1   (led1),
    .o_LED_2   (led2),
    .o_LED_3   (led3),
    .o_LED_4   (led4),
    .o_Mode    (mode)
  );

  // Written LED1 first, matching the "1000" notation.
  assign led_vec = {led1, led2, led3, led4};

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: every observed output change must match the next queued entry.
  always @(negedge clk) begin
    if (mon_en && ({mode, led_vec} !== prev)) begin
      prev = {mode, led_vec};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change: edge %0d mode %0d led %b, required no change",
                 edge_cnt, mode, led_vec);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != edge_cnt || mon_e.mode !== mode || mon_e.led !== led_vec) begin
          bad++;
          $display("FAIL output_change: got edge %0d mode %0d led %b, required edge %0d mode %0d led %b",
                   edge_cnt, mode, led_vec, mon_e.cyc, mon_e.mode, mon_e.led);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int c, input logic [1:0] m, input logic [3:0] l);
    exp_t e;
    e.cyc  = c;
    e.mode = m;
    e.led  = l;
    q.push_back(e);
  endtask

  // Press mask for 10 cycles after waiting w; r is the edge count at release.
  task automatic press_release(input logic [3:0] mask, input int w, output int r);
    wait_cyc(w);
    sw = sw | mask;
    wait_cyc(10);
    r  = edge_cnt;
    sw = sw & ~mask;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: run did not complete, pending=%0d", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int e;
    int x;
    rst = 1'b1;
    sw  = '0;
    wait_cyc(3);
    total++;
    if (mode !== 2'd0 || led_vec !== 4'b0000) begin
      bad++;
      $display("FAIL reset_state: got mode %0d led %b, required mode 0 led 0000", mode, led_vec);
    end
    rst    = 1'b0;
    mon_en = 1'b1;

    // MANUAL toggle of LED1 on and back off
    press_release(4'b0001, 0, r); expect_at(r + LAT, 2'd0, 4'b1000); wait_cyc(10);
    press_release(4'b0001, 0, r); expect_at(r + LAT, 2'd0, 4'b0000); wait_cyc(10);

    // short glitch on switch 2: no change at all
    sw[1] = 1'b1; wait_cyc(3); sw[1] = 1'b0; wait_cyc(12);

    // manual bits 1 and 3 set
    press_release(4'b0001, 0, r); expect_at(r + LAT, 2'd0, 4'b1000); wait_cyc(10);
    press_release(4'b0100, 0, r); expect_at(r + LAT, 2'd0, 4'b1010); wait_cyc(10);

    // switches 4+1 together: mode only, then a forward chase
    press_release(4'b1001, 0, r);
    e = r + LAT;
    expect_at(e,      2'd1, 4'b1000);
    expect_at(e + 3,  2'd1, 4'b0100);
    expect_at(e + 6,  2'd1, 4'b0010);
    expect_at(e + 9,  2'd1, 4'b0001);
    expect_at(e + 12, 2'd1, 4'b1000);
    expect_at(e + 15, 2'd1, 4'b0100);
    expect_at(e + 18, 2'd1, 4'b0010);
    expect_at(e + 20, 2'd2, 4'b1111);
    press_release(4'b1000, 10, r);

    // BLINK: 5 on, 5 off, then OFF
    x = r + LAT;
    expect_at(x + 5,  2'd2, 4'b0000);
    expect_at(x + 10, 2'd2, 4'b1111);
    expect_at(x + 15, 2'd2, 4'b0000);
    expect_at(x + 20, 2'd3, 4'b0000);
    press_release(4'b1000, 10, r);

    // OFF ignores switches 1 and 2; back to MANUAL with bits intact
    press_release(4'b0011, 10, r);
    press_release(4'b1000, 10, r); expect_at(r + LAT, 2'd0, 4'b1010); wait_cyc(10);

    // CHASE with a direction flip between the 2nd and 3rd step
    sw = sw | 4'b1001;
    wait_cyc(10);
    r     = edge_cnt;
    sw[3] = 1'b0;
    e     = r + LAT;
    expect_at(e,      2'd1, 4'b1000);
    expect_at(e + 3,  2'd1, 4'b0100);
    expect_at(e + 6,  2'd1, 4'b0010);
    expect_at(e + 9,  2'd1, 4'b0100);
    expect_at(e + 12, 2'd1, 4'b1000);
    expect_at(e + 15, 2'd1, 4'b0001);
    expect_at(e + 18, 2'd1, 4'b0010);
    wait_cyc(7);
    sw[0] = 1'b0;
    wait_cyc(e + 19 - edge_cnt);

    // async reset with LED3 lit and switch 2 mid-press
    expect_at(e + 20, 2'd0, 4'b0000);
    sw[1] = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++;
    if (mode !== 2'd0 || led_vec !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async: got mode %0d led %b, required mode 0 led 0000", mode, led_vec);
    end
    wait_cyc(3);
    rst   = 1'b0;
    sw[1] = 1'b0;
    wait_cyc(15);

    // first release after reset needs a full debounce, manual bits cleared
    press_release(4'b0001, 0, r); expect_at(r + LAT, 2'd0, 4'b1000); wait_cyc(10);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_expected: got %0d entries left, required 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sequence_ctrl.md
LED_SEQUENCE_CTRL -- requirements
Module: led_sequence_ctrl

Interface
REQ-001 Parameter DEBOUNCE_LIMIT, default 250000: consecutive clocks a synchronized switch level must hold before it is accepted (minimum 2).
REQ-002 Parameter CHASE_TICKS, default 6250000: clocks per chase step (minimum 2).
REQ-003 Parameter BLINK_TICKS, default 12500000: clocks per blink half-period (minimum 2).
REQ-004 i_Clk  input  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-005 i_Rst  input  1  reset, asynchronous, active-high.
REQ-006 i_Switch_1..i_Switch_4  input  1 each  raw, asynchronous push-switch levels (1 = pressed).
REQ-007 o_LED_1..o_LED_4  output  1 each  LED drives (1 = lit), driven directly from registers.
REQ-008 o_Mode  output  2  current mode: 0 MANUAL, 1 CHASE, 2 BLINK, 3 OFF.

Function
REQ-009 Each switch SHALL pass through a two-flop synchronizer before any other logic.
REQ-010 Each switch SHALL have its own debounce counter, which increments on every edge where the synchronized level differs from the debounced level and clears on any edge where they match.
REQ-011 When a debounce counter reaches DEBOUNCE_LIMIT, the debounced level SHALL take the synchronized level on that edge and the counter SHALL clear.
REQ-012 A release event for switch k SHALL be a one-cycle pulse, asserted when the previous debounced level is 1 and the current debounced level is 0; press edges produce no event.
REQ-013 End-to-end latency: a raw release held stable SHALL change the affected LED register on rising edge DEBOUNCE_LIMIT+3, counting the first edge that samples the new level as edge 1.
REQ-014 A raw glitch shorter than DEBOUNCE_LIMIT synchronized cycles SHALL produce no event.
REQ-015 Mode FSM: a switch 4 release SHALL advance MANUAL->CHASE->BLINK->OFF->MANUAL, wrapping after OFF.
REQ-016 MANUAL:
- a release on switch k (k = 1..3) toggles a retained manual bit k;
- LED1..3 show the manual bits; LED4 = 0;
- the manual bits SHALL be preserved across excursions to other modes.
REQ-017 CHASE:
- on entry, the pattern SHALL be LED1..4 = 1000, direction forward, and the tick counter zeroed;
- every CHASE_TICKS clocks the single lit LED moves one position: forward 1->2->3->4->1, reverse 4->3->2->1->4;
- a switch 1 release inverts direction without resetting the tick counter.
REQ-018 BLINK:
- on entry, all four LEDs SHALL be lit and the tick counter zeroed;
- all four LEDs invert together every BLINK_TICKS clocks.
REQ-019 OFF: all LEDs 0, and switch 1..3 releases are ignored.
REQ-020 Simultaneous events: a switch 4 release in the same cycle as any other release SHALL advance the mode only, and the other releases SHALL be discarded.
REQ-021 Releases on switches 2..3 outside MANUAL, and on switch 1 outside MANUAL/CHASE, SHALL be ignored.
REQ-022 On a mode change, the LED outputs SHALL reflect the new mode's entry pattern on the same edge as the mode register update.
REQ-023 Tick counters SHALL wrap to 0 on reaching their limit and SHALL not run in MANUAL or OFF.

Reset
REQ-024 Asserting i_Rst SHALL immediately, without waiting for a clock edge, clear all of the following: synchronizers, debounced levels, debounce counters, tick counters, manual bits, o_LED_1..4 = 0, o_Mode = 0 (MANUAL), chase direction forward.
REQ-025 Reset asserted mid-debounce or mid-chase SHALL discard all partial progress.
REQ-026 After deassertion, the first release event SHALL require a full new debounce interval.

Verification (DEBOUNCE_LIMIT=4, CHASE_TICKS=3, BLINK_TICKS=5)
REQ-027 Switch 1 press then release, each held 10 clocks, in MANUAL -> o_LED_1 rises on edge 7 after release sampling; o_LED_2..4 stay 0; second press/release returns o_LED_1 to 0.
REQ-028 3-clock raw pulse on switch 2 -> no LED change and o_Mode unchanged.
REQ-029 Switch 4 release once -> o_Mode=1, LEDs 1000, then 0100 three clocks later, then 0010; switch 1 release -> next step reverses to 0100.
REQ-030 Switches 4 and 1 released on the same clock in MANUAL -> o_Mode=1; manual bit 1 unchanged when returning to MANUAL after three further switch 4 releases.
REQ-031 In BLINK -> LEDs 1111 for 5 clocks, 0000 for 5, repeating; switch 4 release -> o_Mode=3, LEDs 0000.
REQ-032 i_Rst pulsed asynchronously mid-CHASE with LED3 lit -> outputs 0000, o_Mode=0 before the next clock edge; a release ending at reset deassertion is not counted.
